// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU encodings: opcode and sequencer state enums.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Decoder/hazard-side bundle for the MDU: op request, flush, status and HI/LO.
interface mdu_ctrl_if #(
  parameter int unsigned DW = 32
);
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_step #(
  parameter int unsigned DW = 32
) (
  input  logic [2*DW-1:0] acc,
  input  logic [DW-1:0]   opnd,
  input  logic            is_div,
  output logic [2*DW-1:0] acc_nxt,
  output logic            q_bit
);
  logic [DW:0] sum;
  logic [DW:0] rem_sh;
  logic [DW:0] diff;

  always_comb begin
    sum     = {1'b0, acc[2*DW-1:DW]} + {1'b0, opnd};
    rem_sh  = acc[2*DW-1:DW-1];
    diff    = rem_sh - {1'b0, opnd};
    q_bit   = 1'b0;
    acc_nxt = acc;
    if (is_div) begin
      // rem_sh < 2*divisor, so diff[DW] is exactly the borrow
      q_bit   = ~diff[DW];
      acc_nxt = {(q_bit ? diff[DW-1:0] : rem_sh[DW-1:0]), acc[DW-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_nxt = {sum, acc[DW-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*DW-1:1]};
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO. Define MDU_FAST_MUL_EN to
// replace the iterative multiply with a single-cycle multiplier.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rstn,
  mdu_ctrl_if.slave bus
);
  localparam int unsigned AW = 2 * DW;

  mdu_state_e    state_q, state_d;
  mdu_op_e       op_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, step_acc, prod_fix;
  logic [DW-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic          is_div_q, is_div_d, dbz_q, dbz_d;
  logic          neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  logic          sgn, step_q;

  assign op_e = mdu_op_e'(bus.op);

  mdu_step #(.DW(DW)) u_step (
    .acc     (acc_q),
    .opnd    (opnd_q),
    .is_div  (is_div_q),
    .acc_nxt (step_acc),
    .q_bit   (step_q)
  );

  always_comb begin
    sgn      = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    mag_a    = (sgn && bus.a[DW-1]) ? -bus.a : bus.a;
    mag_b    = (sgn && bus.b[DW-1]) ? -bus.b : bus.b;
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
    rem_fix  = rneg_q ? -acc_q[AW-1:DW] : acc_q[AW-1:DW];

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    done_d   = 1'b0;

    case (state_q)
      MDU_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (op_e)
            MDU_MTHI: hi_d = bus.a;
            MDU_MTLO: lo_d = bus.a;
            MDU_MULT, MDU_MULTU: begin
              is_div_d = 1'b0;
              dbz_d    = 1'b0;
              neg_d    = sgn & (bus.a[DW-1] ^ bus.b[DW-1]);
              rneg_d   = 1'b0;
              opnd_d   = mag_a;
              cnt_d    = CNT_W'(DW - 1);
`ifdef MDU_FAST_MUL_EN
              acc_d    = AW'(mag_a) * AW'(mag_b);
              state_d  = MDU_FIX;
`else
              acc_d    = {{DW{1'b0}}, mag_b};
              state_d  = MDU_CALC;
`endif
            end
            MDU_DIV, MDU_DIVU: begin
              is_div_d = 1'b1;
              neg_d    = sgn & (bus.a[DW-1] ^ bus.b[DW-1]);
              rneg_d   = sgn & bus.a[DW-1];
              opnd_d   = mag_b;
              cnt_d    = CNT_W'(DW - 1);
              if (bus.b == '0) begin
                // raw dividend is parked in acc so FIX can return it as HI
                dbz_d   = 1'b1;
                acc_d   = {{DW{1'b0}}, bus.a};
                state_d = MDU_FIX;
              end else begin
                dbz_d   = 1'b0;
                acc_d   = {{DW{1'b0}}, mag_a};
                state_d = MDU_CALC;
              end
            end
            default: ;
          endcase
        end
      end
      MDU_CALC: begin
        if (bus.flush) begin
          state_d = MDU_IDLE;
        end else begin
          // step leaves the quotient slot clear; fill it from q_bit
          acc_d = {step_acc[AW-1:1], step_acc[0] | step_q};
          if (cnt_q == '0) begin
            state_d = MDU_FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MDU_FIX: begin
        state_d = MDU_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (dbz_q) begin
            hi_d = acc_q[DW-1:0];
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != MDU_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO/busy length,
// a monitor pops and compares on every done pulse.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int unsigned MUL_BUSY = 1;
`else
  localparam int unsigned MUL_BUSY = 33;
`endif
  localparam int unsigned DIV_BUSY = 33;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned busy;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_bad;
  exp_t sb_q[$];
  int unsigned busy_run;

  mdu_ctrl_if #(.DW(32)) bus ();

  mdu_ctrl #(.DW(32), .CNT_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        busy_run = 0;
      end else if (bus.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_hi"}, bus.hi, e.hi);
          chk({e.name, "_lo"}, bus.lo, e.lo);
          chk({e.name, "_busy_cycles"}, busy_run, e.busy);
        end
        busy_run = 0;
      end else if (bus.busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int unsigned ebusy);
    exp_t e;
    e.name = nm; e.hi = ehi; e.lo = elo; e.busy = ebusy;
    sb_q.push_back(e);
    issue(op, a, b);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      chk({nm, "_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    int dones;
    n_vec = 0;
    n_bad = 0;
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rstn = 1'b1;

    run_op("mult_neg2x3", MDU_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_BUSY);
    wait_done("mult_neg2x3");
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_BUSY);
    wait_done("multu_max");
    run_op("mult_neg5xneg4", MDU_MULT, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h0, 32'd20, MUL_BUSY);
    wait_done("mult_neg5xneg4");
    run_op("div_neg7_2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY);
    wait_done("div_neg7_2");
    run_op("div_7_neg2", MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, DIV_BUSY);
    wait_done("div_7_neg2");
    run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY);
    wait_done("divu_100_7");
    run_op("divu_by0", MDU_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1);
    wait_done("divu_by0");
    run_op("div_neg_by0", MDU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    wait_done("div_neg_by0");
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_BUSY);
    wait_done("div_ovf");

    // start while busy must be ignored
    run_op("divu_busy_start", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_BUSY);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("divu_busy_start");

    issue(MDU_MTHI, 32'hA5A5A5A5, 32'd0);
    chk("mthi_hi", bus.hi, 32'hA5A5A5A5);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(MDU_MTLO, 32'h5A5A5A5A, 32'd0);
    chk("mtlo_lo", bus.lo, 32'h5A5A5A5A);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);

    // flush with start in IDLE drops the op
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MDU_MTHI; bus.a = 32'h0;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_mthi_hi", bus.hi, 32'hA5A5A5A5);

    issue(3'd7, 32'h11111111, 32'h22222222);
    chk("undef_busy", {31'd0, bus.busy}, 32'd0);
    chk("undef_hi", bus.hi, 32'hA5A5A5A5);
    chk("undef_lo", bus.lo, 32'h5A5A5A5A);

    // DIV flushed at CALC step 10
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy_low", {31'd0, bus.busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    chk("flush_no_done", 32'(dones), 32'd0);
    chk("flush_hi", bus.hi, 32'hA5A5A5A5);
    chk("flush_lo", bus.lo, 32'h5A5A5A5A);

    // asynchronous reset during CALC
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_op("mult_6x7", MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, MUL_BUSY);
    wait_done("mult_6x7");
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
